// File: rtl/chip8_fbuf_pkg.sv
// Shared types and sizes for the framebuffer arbiter and its clear sequencer.
package chip8_fbuf_pkg;

  localparam int FBUF_ADDR_W = 9;
  localparam int FBUF_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_CPU
  } owner_e;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

endpackage

// File: rtl/fbuf_clear_seq.sv
// Screen-clear sequencer: walks every framebuffer word once, writing only in
// cycles the display leaves free.
//
//   state    | meaning
//   ST_IDLE  | no clear running, waiting for clr_start
//   ST_CLEAR | writing clr_cnt whenever slot_free, ignores clr_start
module fbuf_clear_seq
  import chip8_fbuf_pkg::*;
#(
  parameter int ADDR_W = FBUF_ADDR_W
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              clr_start,
  input  logic              slot_free,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  clr_state_e      state;
  logic [ADDR_W:0] clr_cnt;
  logic [ADDR_W:0] cnt_nxt;

  assign cnt_nxt  = clr_cnt + (ADDR_W + 1)'(1);
  assign clr_busy = (state == ST_CLEAR);
  assign clr_we   = clr_busy & slot_free;
  assign clr_addr = clr_cnt[ADDR_W-1:0];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= ST_IDLE;
      clr_cnt  <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (slot_free) begin
            // carry into the top bit means the last word was just written
            if (cnt_nxt[ADDR_W]) begin
              state    <= ST_IDLE;
              clr_cnt  <= '0;
              clr_done <= 1'b1;
            end else begin
              clr_cnt <= cnt_nxt;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fbuf_arbiter.sv
// Single-port framebuffer arbiter: display > clear > CPU, with registered CPU
// read return two cycles after acceptance.
module fbuf_arbiter
  import chip8_fbuf_pkg::*;
#(
  parameter int                 ADDR_W    = FBUF_ADDR_W,
  parameter int                 DATA_W    = FBUF_DATA_W,
  parameter logic [DATA_W-1:0]  CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              cpu_go;
  owner_e            owner;

  fbuf_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk       (clk),
    .res_n     (res_n),
    .clr_start (clr_start),
    .slot_free (!disp_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we)
  );

  assign disp_data = ram_rdata;
  assign cpu_ready = !disp_req & !clr_busy & res_n;
  assign cpu_go    = cpu_req & cpu_ready;

  always_comb begin
    ram_addr  = disp_addr;
    ram_we    = 1'b0;
    ram_wdata = cpu_wdata;
    if (disp_req) begin
      ram_addr = disp_addr;
    end else if (clr_we) begin
      ram_addr  = clr_addr;
      ram_we    = 1'b1;
      ram_wdata = CLR_VALUE;
    end else if (cpu_go) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
    end
    ram_we = ram_we & res_n;
  end

  // owner tags the read issued this cycle; its data arrives next cycle
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      owner      <= OWN_NONE;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      if (disp_req)             owner <= OWN_DISP;
      else if (cpu_go && !cpu_we) owner <= OWN_CPU;
      else                      owner <= OWN_NONE;
      cpu_rvalid <= (owner == OWN_CPU);
      if (owner == OWN_CPU) cpu_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_fbuf_arbiter.sv
// Scoreboard bench for fbuf_arbiter with a behavioural 512x16 synchronous RAM.
`timescale 1ns/1ps
module tb_fbuf_arbiter;

  logic        clk = 1'b0;
  logic        res_n;
  logic        disp_req;
  logic [8:0]  disp_addr;
  logic [15:0] disp_data;
  logic        cpu_req, cpu_we;
  logic [8:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        clr_start, clr_busy, clr_done;
  logic [8:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  always #5 clk = ~clk;

  fbuf_arbiter dut (
    .clk(clk), .res_n(res_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // bench RAM; the pre_* port lets the bench preload contents
  logic [15:0] mem [512];
  logic        pre_we = 1'b0;
  logic [8:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] cpu_q[$];
  logic [15:0] disp_q[$];
  logic disp_chk = 1'b0;
  logic disp_dly = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) disp_dly <= disp_req & res_n & disp_chk;

  always @(negedge clk) begin
    if (disp_dly) begin
      if (disp_q.size() == 0) chk("disp_unexpected", 32'(disp_data), 32'hDEAD_BEEF);
      else chk("disp_data", 32'(disp_data), 32'(disp_q.pop_front()));
    end
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'(cpu_rdata), 32'hDEAD_BEEF);
      else chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] base);
    for (int i = 0; i < 512; i++) begin
      step;
      pre_we   = 1'b1;
      pre_addr = 9'(i);
      pre_data = base | 16'(i);
    end
    step;
    pre_we = 1'b0;
  endtask

  task automatic poke(input logic [8:0] a, input logic [15:0] d);
    step;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step;
    pre_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_addr, busy_cnt, disp_cnt, wr_cnt, done_cnt, cyc;
    logic pulsed, ended;
    res_n = 1'b0; disp_req = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; clr_start = 1'b0;

    // reset values, forced-off write and ready while in reset
    step;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h003; clr_start = 1'b1;
    #3;
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    chk("rst_clr_done", 32'(clr_done), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_cpu_ready", 32'(cpu_ready), 0);
    step;
    cpu_req = 1'b0; cpu_we = 1'b0; clr_start = 1'b0;
    fill(16'hF000);
    poke(9'h005, 16'hA55A);
    step; res_n = 1'b1;
    step; #3;
    chk("post_rst_busy", 32'(clr_busy), 0);

    // display only
    disp_chk = 1'b1;
    step;
    disp_req = 1'b1; disp_addr = 9'h005; disp_q.push_back(16'hA55A);
    #3;
    chk("disp_ram_addr", 32'(ram_addr), 32'h005);
    chk("disp_ram_we", 32'(ram_we), 0);
    chk("disp_cpu_ready", 32'(cpu_ready), 0);
    step;
    disp_req = 1'b0;
    #3;
    chk("idle_cpu_ready", 32'(cpu_ready), 1);

    // CPU write then read
    step;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h100; cpu_wdata = 16'h1234;
    #3;
    chk("wr_ready", 32'(cpu_ready), 1);
    chk("wr_ram_we", 32'(ram_we), 1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h100);
    chk("wr_ram_wdata", 32'(ram_wdata), 32'h1234);
    step;
    cpu_we = 1'b0; cpu_q.push_back(16'h1234);
    #3;
    chk("rd_ready", 32'(cpu_ready), 1);
    chk("rd_ram_we", 32'(ram_we), 0);
    chk("rd_ram_addr", 32'(ram_addr), 32'h100);
    step;
    cpu_req = 1'b0;
    #3;
    chk("rvalid_n1", 32'(cpu_rvalid), 0);
    step; #3;
    chk("rvalid_n2", 32'(cpu_rvalid), 1);
    step; #3;
    chk("rvalid_n3", 32'(cpu_rvalid), 0);
    chk("rdata_hold", 32'(cpu_rdata), 32'h1234);

    // contention: display holds the port for three cycles
    for (int i = 0; i < 3; i++) begin
      step;
      disp_req = 1'b1; disp_addr = 9'(5 + i);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h010;
      disp_q.push_back(i == 0 ? 16'hA55A : (16'hF000 | 16'(5 + i)));
      #3;
      chk("cont_ready_low", 32'(cpu_ready), 0);
      chk("cont_ram_addr", 32'(ram_addr), 32'(5 + i));
    end
    step;
    disp_req = 1'b0; cpu_q.push_back(16'hF010);
    #3;
    chk("cont_ready_4th", 32'(cpu_ready), 1);
    chk("cont_cpu_addr", 32'(ram_addr), 32'h010);
    step; cpu_req = 1'b0;
    step; step; step;
    disp_chk = 1'b0;

    // clear with 50% display interleave and a second clr_start at clr_cnt=200
    step;
    clr_start = 1'b1;
    #3;
    chk("clr_start_cycle_busy", 32'(clr_busy), 0);
    exp_addr = 0; busy_cnt = 0; disp_cnt = 0; wr_cnt = 0; done_cnt = 0;
    pulsed = 1'b0; ended = 1'b0; cyc = 0;
    while (!ended && cyc < 2000) begin
      step;
      clr_start = (exp_addr == 200) && !pulsed;
      if (clr_start) pulsed = 1'b1;
      disp_req = (cyc % 2 == 0);
      disp_addr = 9'h005;
      #3;
      if (clr_done) done_cnt++;
      if (!clr_busy) begin
        ended = 1'b1;
        chk("clr_done_after_last", 32'(clr_done), 1);
      end else begin
        busy_cnt++;
        chk("clr_cpu_ready", 32'(cpu_ready), 0);
        if (disp_req) begin
          disp_cnt++;
          chk("clr_disp_no_we", 32'(ram_we), 0);
        end else begin
          chk("clr_we", 32'(ram_we), 1);
          chk("clr_addr", 32'(ram_addr), 32'(exp_addr));
          chk("clr_wdata", 32'(ram_wdata), 0);
          exp_addr++;
        end
        if (ram_we) wr_cnt++;
      end
      cyc++;
    end
    disp_req = 1'b0; clr_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step; #3;
      if (clr_done) done_cnt++;
    end
    chk("clr_writes", 32'(wr_cnt), 512);
    chk("clr_busy_cycles", 32'(busy_cnt), 32'(512 + disp_cnt));
    chk("clr_done_count", 32'(done_cnt), 1);
    chk("clr_restart_pulsed", 32'(pulsed), 1);

    // every word reads back as the clear value
    for (int i = 0; i < 512; i++) begin
      step;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'(i);
      cpu_q.push_back(16'h0000);
    end
    step; cpu_req = 1'b0;
    step; step; step;

    // reset in the middle of a clear
    fill(16'hB000);
    step; clr_start = 1'b1;
    step; clr_start = 1'b0;
    for (int k = 1; k < 300; k++) step;
    #3;
    chk("mid_clr_addr_299", 32'(ram_addr), 299);
    step;
    res_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h1F0;
    #3;
    chk("rst_mid_busy", 32'(clr_busy), 0);
    chk("rst_mid_we", 32'(ram_we), 0);
    chk("rst_mid_done", 32'(clr_done), 0);
    step; #3;
    chk("rst_hold_we", 32'(ram_we), 0);
    step;
    res_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step; #3;
      if (clr_done) done_cnt++;
    end
    chk("rst_mid_no_done", 32'(done_cnt), 0);
    begin
      logic [8:0]  ra [5];
      logic [15:0] rd [5];
      ra = '{9'd0, 9'd299, 9'd300, 9'd301, 9'd511};
      rd = '{16'h0000, 16'h0000, 16'hB12C, 16'hB12D, 16'hB1FF};
      for (int i = 0; i < 5; i++) begin
        step;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ra[i];
        cpu_q.push_back(rd[i]);
      end
    end
    step; cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) step;
    #3;
    chk("cpu_q_drained", 32'(cpu_q.size()), 0);
    chk("disp_q_drained", 32'(disp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fbuf_arbiter.md
# fbuf_arbiter

Single-port framebuffer arbiter shared by the display fetch path, the CPU and a built-in screen-clear sequencer. It sits between the 512×16 framebuffer RAM and its three users. The display keeps fixed one-cycle read latency and absolute priority. CPU sprite/pixel accesses and the CLS clear are interleaved into the cycles the display leaves free.

## Interface

Parameters:
- ADDR_W, 9, framebuffer word-address width
- DATA_W, 16, framebuffer word width
- CLR_VALUE, 16'h0000, word written by the clear sequencer

Ports:
- clk  in  1  system clock
- res_n  in  1  asynchronous, active-low reset
- disp_req  in  1  display reads disp_addr this cycle
- disp_addr  in  ADDR_W  display read address
- disp_data  out  DATA_W  display read data; equals ram_rdata (pass-through)
- cpu_req  in  1  CPU access request; held until accepted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  CPU access accepted this cycle when cpu_req=1
- cpu_rdata  out  DATA_W  registered CPU read data
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata updated
- clr_start  in  1  start full-buffer clear (pulse)
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after last clear write
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, one cycle after address

## Operation

- **Priority per cycle:** display > clear > CPU. The RAM port signals are a combinational mux of the winner.
- **Display slot (disp_req=1):**
  - ram_addr=disp_addr, ram_we=0.
  - Nothing else is issued that cycle.
- **Clear slot (disp_req=0, clr_busy=1):**
  - ram_addr=clr_cnt, ram_we=1, ram_wdata=CLR_VALUE.
  - clr_cnt increments.
- **CPU slot:**
  - cpu_ready = !disp_req & !clr_busy & res_n.
  - On cpu_req & cpu_ready: ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata.
  - Writes complete in that cycle.
- **Idle slot:** ram_addr=disp_addr, ram_we=0.
- **Read-owner register:**
  - Records OWN_DISP, OWN_CPU or OWN_NONE for the read issued each cycle.
  - When the owner is OWN_CPU, cpu_rdata loads ram_rdata at the end of the following cycle and cpu_rvalid pulses in the cycle after that.
- **Clear FSM:** states IDLE and CLEAR.
  - IDLE → CLEAR on clr_start; clr_cnt set to 0.
  - CLEAR → IDLE after the write at address 2^ADDR_W−1; clr_done pulses in the next cycle.
  - clr_start while in CLEAR is ignored (no restart).
  - clr_busy = (state==CLEAR).
- **Width rule:** clr_cnt is ADDR_W+1 bits wide. Termination is detected on the carry into bit ADDR_W; no wrap is written.

## Timing

- **Reset values (res_n=0):**
  - Registers: state=IDLE, clr_cnt=0, owner=OWN_NONE.
  - Outputs: cpu_rdata=0, cpu_rvalid=0, clr_busy=0, clr_done=0.
  - ram_we and cpu_ready are forced to 0 while res_n=0.
- **Reset mid-clear:** the clear aborts immediately, no clr_done pulse, partially cleared contents remain.
- **Display latency:** 1 cycle (address at N, disp_data valid at N+1), unchanged from a direct RAM connection.
- **CPU read latency:** accepted at N, cpu_rvalid=1 and cpu_rdata valid at N+2. cpu_rdata holds until the next CPU read.
- **CPU write latency:** accepted at N, RAM written at the clk edge ending N.
- **Clear duration:** 2^ADDR_W cycles plus the number of cycles with disp_req=1 during the clear.
- **Simultaneous events:**
  - clr_start together with an acceptable cpu_req: the CPU access is accepted in that cycle and the clear starts next cycle.
  - A CPU request pending across a clear is stalled until clr_busy falls.

## Structure

- **Package chip8_fbuf_pkg:**
  - owner enum (OWN_NONE, OWN_DISP, OWN_CPU)
  - clear-FSM state enum (ST_IDLE, ST_CLEAR)
  - FBUF_ADDR_W = 9, FBUF_DATA_W = 16
- **Sub-module fbuf_clear_seq:** contains the clear FSM, clr_cnt and the clr_done pulse. It takes a `slot_free` input and outputs `clr_addr`/`clr_we`. The top module keeps the mux, the owner register and cpu_rdata.

## Test plan

- **Display only:** disp_req=1 at addr 0x005 with RAM[5]=0xA55A → ram_addr=0x005, ram_we=0, disp_data=0xA55A next cycle; cpu_ready=0 throughout.
- **CPU write then read, display idle:** write 0x1234 to 0x100, then read 0x100 → cpu_ready=1 on both; cpu_rvalid pulses 2 cycles after the read accept with cpu_rdata=0x1234.
- **Contention:** cpu_req read of 0x010 while disp_req is high for 3 cycles → cpu_ready low for those 3 cycles and accepted on the 4th; display data unaffected.
- **Clear with display interleave:** clr_start with disp_req toggling 50% → clr_busy high for 512 free slots plus every display cycle; all 512 words read back 0x0000; clr_done pulses exactly once.
- **clr_start during CLEAR:** second pulse at clr_cnt=200 → no restart; total free-slot writes = 512.
- **Reset mid-clear:** res_n low at clr_cnt=300 → clr_busy=0 immediately, no clr_done, words 300–511 retain their old values, ram_we=0 while in reset.
